l2_bus_responder: RTL

//   Next-level (L2/memory bus) end of the cache output protocol. Accepts one

---
 rtl/l2_bus_if.sv | 31 +++
 rtl/l2_bus_responder.sv | 116 +++++++++++
 2 files changed

// File: rtl/l2_bus_if.sv
// Cache-to-L2 message handshake, timed bus transaction outputs and statistics.
// The master drives messages in; the slave sequences them onto the bus.
interface l2_bus_if #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [ADDR_W-1:0] req_wb_addr;
  logic              bus_valid;
  logic [1:0]        bus_op;
  logic [ADDR_W-1:0] bus_addr;
  logic              busy;
  logic              resp_valid;
  logic [CNT_W-1:0]  rd_count;
  logic [CNT_W-1:0]  wr_count;

  modport master (
    output req_valid, req_op, req_addr, req_wb_addr,
    input  req_ready, bus_valid, bus_op, bus_addr, busy, resp_valid,
           rd_count, wr_count
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wb_addr,
    output req_ready, bus_valid, bus_op, bus_addr, busy, resp_valid,
           rd_count, wr_count
  );
endinterface

// File: rtl/l2_bus_responder.sv
// L2-side responder: turns one cache output message into a write and/or read
// bus transaction of LAT cycles each, then pulses resp_valid once.
module l2_bus_responder #(
  parameter int ADDR_W = 32,
  parameter int LAT    = 4,
  parameter int CNT_W  = 32
) (
  input logic   clk,
  input logic   rst,
  l2_bus_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [1:0] OP_READ  = 2'd0;
  localparam logic [1:0] OP_WRITE = 2'd1;
  localparam logic [1:0] OP_RW    = 2'd2;
  localparam logic [1:0] OP_NOP   = 2'd3;

  localparam int         LW       = $clog2(LAT + 1);
  localparam logic [LW-1:0] LAT_LAST = LW'(LAT - 1);

  logic [1:0]        state;
  logic [LW-1:0]     lat_cnt;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] addr_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Combinational so a new message can be taken the same cycle reset drops.
  assign bus.req_ready = (state == S_IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      lat_cnt        <= '0;
      bus.bus_valid  <= 1'b0;
      bus.bus_op     <= OP_NOP;
      bus.bus_addr   <= '0;
      bus.busy       <= 1'b0;
      bus.resp_valid <= 1'b0;
      bus.rd_count   <= '0;
      bus.wr_count   <= '0;
    end else begin
      bus.bus_valid  <= 1'b0;
      bus.resp_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q     <= bus.req_op;
            addr_q   <= bus.req_addr;
            lat_cnt  <= '0;
            bus.busy <= 1'b1;
            case (bus.req_op)
              OP_READ: begin
                state         <= S_RD;
                bus.bus_valid <= 1'b1;
                bus.bus_op    <= OP_READ;
                bus.bus_addr  <= bus.req_addr;
                bus.rd_count  <= sat_inc(bus.rd_count);
              end
              OP_WRITE, OP_RW: begin
                state         <= S_WR;
                bus.bus_valid <= 1'b1;
                bus.bus_op    <= OP_WRITE;
                bus.bus_addr  <= bus.req_wb_addr;
                bus.wr_count  <= sat_inc(bus.wr_count);
              end
              default: begin
                state          <= S_DONE;
                bus.resp_valid <= 1'b1;
              end
            endcase
          end
        end
        S_WR: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt <= '0;
            // RW_OUT chains straight into the fill read with a fresh pulse.
            if (op_q == OP_RW) begin
              state         <= S_RD;
              bus.bus_valid <= 1'b1;
              bus.bus_op    <= OP_READ;
              bus.bus_addr  <= addr_q;
              bus.rd_count  <= sat_inc(bus.rd_count);
            end else begin
              state          <= S_DONE;
              bus.bus_op     <= OP_NOP;
              bus.resp_valid <= 1'b1;
            end
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        S_RD: begin
          if (lat_cnt == LAT_LAST) begin
            lat_cnt        <= '0;
            state          <= S_DONE;
            bus.bus_op     <= OP_NOP;
            bus.resp_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt + LW'(1);
          end
        end
        default: begin
          state    <= S_IDLE;
          bus.busy <= 1'b0;
        end
      endcase
    end
  end
endmodule
